// File: rtl/rcb_host_wr_arb.sv
// RCB responder end of the host write path: captures one host write and
// arbitrates it against lookup reads onto a single-port byte-enabled RAM.
module rcb_host_wr_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hpb_wr_req,
  input  logic [ADDR_WIDTH-1:0] hpb_wr_addr,
  input  logic [DATA_WIDTH-1:0] hpb_wr_data,
  input  logic [BE_WIDTH-1:0]   hpb_wr_byte_en,
  output logic                  rcb_wr_done,
  input  logic                  lkp_valid,
  output logic                  lkp_ready,
  input  logic [ADDR_WIDTH-1:0] lkp_addr,
  output logic                  lkp_rsp_valid,
  output logic [DATA_WIDTH-1:0] lkp_rsp_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BE_WIDTH-1:0]   ram_be,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, PEND, DONE, REL} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic                  done_q, done_d;
  logic                  rd_v_q, rd_v_d;
  logic                  rsp_v_q, rsp_v_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  write_go;
  logic                  lkp_acc;

  assign write_go = (state_q == PEND) &&
                    (!lkp_valid || (starve_q == SMAX));
  assign lkp_ready = !write_go;
  assign lkp_acc   = lkp_valid && lkp_ready;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_be    = '0;
    ram_wdata = '0;
    if (write_go) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = addr_q;
      ram_be    = be_q;
      ram_wdata = data_q;
    end else if (lkp_acc) begin
      ram_en   = 1'b1;
      ram_addr = lkp_addr;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hpb_wr_req) begin
          addr_d   = hpb_wr_addr;
          data_d   = hpb_wr_data;
          be_d     = hpb_wr_byte_en;
          starve_d = '0;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (write_go) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (starve_q != SMAX) begin
          starve_d = starve_q + CW'(1);
        end
      end
      DONE: state_d = REL;
      // req stays high until hpb sees done; wait it out to avoid a re-capture
      REL: if (!hpb_wr_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_v_d     = lkp_acc;
    rsp_v_d    = rd_v_q;
    rsp_data_d = rd_v_q ? ram_rdata : rsp_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      done_q     <= 1'b0;
      rd_v_q     <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      done_q     <= done_d;
      rd_v_q     <= rd_v_d;
      rsp_v_q    <= rsp_v_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rcb_wr_done   = done_q;
  assign lkp_rsp_valid = rsp_v_q;
  assign lkp_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rcb_host_wr_arb.sv
// Bench for rcb_host_wr_arb: directed vectors, corner sequences and a
// randomized run scored against a cycle-level reference of the arbiter.
module tb_rcb_host_wr_arb;

  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hpb_wr_req;
  logic [9:0]  hpb_wr_addr;
  logic [63:0] hpb_wr_data;
  logic [7:0]  hpb_wr_byte_en;
  logic        rcb_wr_done;
  logic        lkp_valid;
  logic        lkp_ready;
  logic [9:0]  lkp_addr;
  logic        lkp_rsp_valid;
  logic [63:0] lkp_rsp_data;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_be;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;

  rcb_host_wr_arb #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(64),
    .BE_WIDTH  (8),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hpb_wr_req    (hpb_wr_req),
    .hpb_wr_addr   (hpb_wr_addr),
    .hpb_wr_data   (hpb_wr_data),
    .hpb_wr_byte_en(hpb_wr_byte_en),
    .rcb_wr_done   (rcb_wr_done),
    .lkp_valid     (lkp_valid),
    .lkp_ready     (lkp_ready),
    .lkp_addr      (lkp_addr),
    .lkp_rsp_valid (lkp_rsp_valid),
    .lkp_rsp_data  (lkp_rsp_data),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_be        (ram_be),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM beside the DUT: byte-enabled write, registered read
  bit [63:0] mem [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 8; b++)
          if (ram_be[b]) mem[ram_addr][8*b+:8] <= ram_wdata[8*b+:8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic [9:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    int          c;
    logic [63:0] d;
  } rq_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit [63:0] ref_mem [1024];
  rq_t       rq [$];
  bit        m_pend, m_wrote, m_rel;
  int        m_dead, m_wcyc;
  logic [9:0]  m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_be;

  logic        s_done, s_rv, s_rdy, s_acc;
  logic [63:0] s_rd;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, score, return just after next posedge
  task automatic tick();
    logic exp_we, exp_done, exp_rv;
    rq_t  h;
    @(negedge clk);
    cyc++;
    s_done = rcb_wr_done;
    s_rv   = lkp_rsp_valid;
    s_rd   = lkp_rsp_data;
    s_rdy  = lkp_ready;
    s_acc  = lkp_valid && lkp_ready;
    if (!reset_n) begin
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_done", rcb_wr_done, 1'b0);
      chk("rst_rsp_valid", lkp_rsp_valid, 1'b0);
      chk("rst_rsp_data", lkp_rsp_data, 64'h0);
      chk("rst_lkp_ready", lkp_ready, 1'b1);
      m_pend  = 0;
      m_wrote = 0;
      m_rel   = 0;
      rq.delete();
    end else begin
      exp_we   = m_pend && !m_wrote && (!lkp_valid || cyc >= m_dead);
      exp_done = m_pend && m_wrote && (cyc == m_wcyc + 1);
      chk("ram_we", ram_we, exp_we);
      chk("rcb_wr_done", rcb_wr_done, exp_done);
      if (exp_done) begin
        for (int b = 0; b < 8; b++)
          if (m_be[b]) ref_mem[m_addr][8*b+:8] = m_data[8*b+:8];
        m_pend = 0;
        m_rel  = 1;
      end else if (m_rel && !hpb_wr_req) begin
        m_rel = 0;
      end else if (!m_pend && !m_rel && hpb_wr_req) begin
        m_pend  = 1;
        m_wrote = 0;
        m_dead  = cyc + 1 + STARVE;
        m_addr  = hpb_wr_addr;
        m_data  = hpb_wr_data;
        m_be    = hpb_wr_byte_en;
      end
      if (exp_we) begin
        chk("wr_en", ram_en, 1'b1);
        chk("wr_addr", ram_addr, m_addr);
        chk("wr_be", ram_be, m_be);
        chk("wr_data", ram_wdata, m_data);
        chk("wr_lkp_ready", lkp_ready, 1'b0);
        m_wrote = 1;
        m_wcyc  = cyc;
      end else begin
        chk("lkp_ready", lkp_ready, 1'b1);
        if (lkp_valid) begin
          chk("rd_en", ram_en, 1'b1);
          chk("rd_addr", ram_addr, lkp_addr);
          chk("rd_be", ram_be, 8'h0);
          rq.push_back('{cyc, ref_mem[lkp_addr]});
        end else begin
          chk("idle_en", ram_en, 1'b0);
          chk("idle_addr", ram_addr, 10'h0);
          chk("idle_be", ram_be, 8'h0);
          chk("idle_wdata", ram_wdata, 64'h0);
        end
      end
      exp_rv = (rq.size() != 0) && (rq[0].c + 2 == cyc);
      chk("rsp_valid", lkp_rsp_valid, exp_rv);
      if (exp_rv) begin
        h = rq.pop_front();
        chk("rsp_data", lkp_rsp_data, h.d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [9:0] a, input logic [63:0] d,
                            input logic [7:0] be, input int hold,
                            output int lat);
    hpb_wr_req     = 1'b1;
    hpb_wr_addr    = a;
    hpb_wr_data    = d;
    hpb_wr_byte_en = be;
    lat = 0;
    tick();
    hpb_wr_addr = ~a;
    hpb_wr_data = ~d;
    hpb_wr_byte_en = ~be;
    while (!s_done && lat < 40) begin
      tick();
      lat++;
    end
    chk("wr_done_seen", s_done, 1'b1);
    repeat (hold) tick();
    hpb_wr_req = 1'b0;
    tick();
  endtask

  task automatic lookup(input logic [9:0] a, input logic [63:0] exp,
                        input string nm);
    int n;
    lkp_valid = 1'b1;
    lkp_addr  = a;
    tick();
    lkp_valid = 1'b0;
    n = 0;
    tick();
    while (!s_rv && n < 4) begin
      tick();
      n++;
    end
    chk({nm, "_valid"}, s_rv, 1'b1);
    chk(nm, s_rd, exp);
  endtask

  initial begin
    vec_t vt [6];
    int   lat, acc, nrdy, ndone, p, hold;
    bit   req_on, got;

    vt[0] = '{10'h005, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[1] = '{10'h005, 64'h0, 8'h0F, 64'hFFFF_FFFF_0000_0000};
    vt[2] = '{10'h005, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'hFFFF_FFFF_0000_0000};
    vt[3] = '{10'h3FF, 64'hA5A5_A5A5_5A5A_5A5A, 8'hF0, 64'hA5A5_A5A5_0000_0000};
    vt[4] = '{10'h000, 64'h0123_4567_89AB_CDEF, 8'h81, 64'h0100_0000_0000_00EF};
    vt[5] = '{10'h012, 64'hCAFE_0000_0000_BEEF, 8'h3C, 64'h1122_0000_0000_7788};

    reset_n = 1'b0;
    hpb_wr_req = 1'b0;
    hpb_wr_addr = '0;
    hpb_wr_data = '0;
    hpb_wr_byte_en = '0;
    lkp_valid = 1'b0;
    lkp_addr = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // idle write, req held 3 cycles past done
    host_write(10'h012, 64'h1122_3344_5566_7788, 8'hFF, 3, lat);
    chk("t1_latency", lat, 2);
    lookup(10'h012, 64'h1122_3344_5566_7788, "t1_readback");

    foreach (vt[i]) begin
      host_write(vt[i].addr, vt[i].data, vt[i].be, 0, lat);
      chk("vec_latency", lat, 2);
      lookup(vt[i].addr, vt[i].exp, "vec_readback");
    end

    // lookups never let up: write forced after STARVE lookups
    lkp_valid = 1'b1;
    lkp_addr = 10'($urandom_range(0, 31));
    hpb_wr_req = 1'b1;
    hpb_wr_addr = 10'h040;
    hpb_wr_data = 64'hDEAD_BEEF_0BAD_F00D;
    hpb_wr_byte_en = 8'hFF;
    tick();
    acc = 0;
    nrdy = 0;
    lat = 0;
    s_done = 1'b0;
    while (!s_done && lat < 40) begin
      lkp_addr = 10'($urandom_range(0, 31));
      tick();
      lat++;
      if (!s_done && s_acc) acc++;
      if (!s_rdy) nrdy++;
    end
    chk("t2_latency", lat, STARVE + 2);
    chk("t2_lookups", acc, STARVE);
    chk("t2_ready_low", nrdy, 1);
    hpb_wr_req = 1'b0;
    repeat (3) tick();
    lkp_valid = 1'b0;
    repeat (3) tick();
    lookup(10'h040, 64'hDEAD_BEEF_0BAD_F00D, "t2_readback");

    // lookup accepted ahead of a write to the same word
    host_write(10'h020, 64'h0000_1111_2222_3333, 8'hFF, 0, lat);
    lkp_valid = 1'b1;
    lkp_addr = 10'h020;
    hpb_wr_req = 1'b1;
    hpb_wr_addr = 10'h020;
    hpb_wr_data = 64'h4444_5555_6666_7777;
    hpb_wr_byte_en = 8'hFF;
    tick();
    chk("t4_accept", s_acc, 1'b1);
    lkp_valid = 1'b0;
    tick();
    tick();
    chk("t4_rsp_valid", s_rv, 1'b1);
    chk("t4_old_data", s_rd, 64'h0000_1111_2222_3333);
    chk("t4_done", s_done, 1'b1);
    hpb_wr_req = 1'b0;
    tick();
    lookup(10'h020, 64'h4444_5555_6666_7777, "t4_new_data");

    // reset while the write is starved
    hpb_wr_req = 1'b1;
    hpb_wr_addr = 10'h030;
    hpb_wr_data = 64'hABAB_ABAB_ABAB_ABAB;
    hpb_wr_byte_en = 8'hFF;
    lkp_valid = 1'b1;
    lkp_addr = 10'h031;
    ndone = 0;
    repeat (4) begin
      tick();
      if (s_done) ndone++;
    end
    reset_n = 1'b0;
    lkp_valid = 1'b0;
    repeat (2) begin
      tick();
      if (s_done) ndone++;
    end
    chk("t5_no_done", ndone, 0);
    reset_n = 1'b1;
    host_write(10'h030, 64'h5555_5555_5555_5555, 8'h0F, 0, lat);
    chk("t5_latency", lat, 2);
    lookup(10'h030, 64'h0000_0000_5555_5555, "t5_readback");

    // back-to-back writes, req low one cycle between
    host_write(10'h000, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 0, lat);
    chk("t6_latency_a", lat, 2);
    host_write(10'h3FF, 64'h7766_5544_3322_1100, 8'hFF, 0, lat);
    chk("t6_latency_b", lat, 2);
    lookup(10'h000, 64'h0F0F_0F0F_0F0F_0F0F, "t6_word_000");
    lookup(10'h3FF, 64'h7766_5544_3322_1100, "t6_word_3ff");

    // randomized traffic scored by the reference in tick()
    req_on = 0;
    got = 0;
    hold = 0;
    p = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) p = $urandom_range(0, 4);
      lkp_valid = ($urandom_range(0, 3) < p);
      lkp_addr = 10'($urandom_range(0, 15));
      hpb_wr_addr = 10'($urandom_range(0, 15));
      hpb_wr_data = {$urandom, $urandom};
      hpb_wr_byte_en = 8'($urandom_range(0, 255));
      if (!req_on) begin
        if ($urandom_range(0, 2) == 0) begin
          hpb_wr_req = 1'b1;
          req_on = 1;
          got = 0;
        end
      end else if (got) begin
        if (hold == 0) begin
          hpb_wr_req = 1'b0;
          req_on = 0;
        end else begin
          hold--;
        end
      end
      tick();
      if (s_done) begin
        got = 1;
        hold = $urandom_range(0, 2);
      end
    end
    lkp_valid = 1'b0;
    if (got || !req_on) hpb_wr_req = 1'b0;
    repeat (20) begin
      tick();
      if (s_done) hpb_wr_req = 1'b0;
    end
    chk("end_rsp_queue", rq.size(), 0);
    chk("end_write_pending", m_pend, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
